multicycle_controller: RTL

- Moore FSM that sequences the existing single-cycle datapath as a multi-cycle machine: FETCH, DECODE, EXEC, MEM, WB.
- Drives the same control set as the combinational control unit (Branch, MemRead, MemToReg, ALUOp, MemWrite, ALUSrc, RegWrite), plus PC and IR write enables.
- Handshakes with a shared instruction/data memory that has variable latency.
- Sits between the IR opcode field and the ALU control / register-file / memory enables.

---
 rtl/mc_pkg.sv | 106 ++++++++++
 rtl/mc_wait_timer.sv | 36 +++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared state/op-class encodings, opcode and ALUOp constants, and the
// state-to-control decode used by multicycle_controller.
`default_nettype none

package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } mc_state_e;

  typedef enum logic [2:0] {
    CLS_R  = 3'd0,
    CLS_I  = 3'd1,
    CLS_LD = 3'd2,
    CLS_ST = 3'd3,
    CLS_BR = 3'd4
  } op_class_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       reg_write;
    logic       busy;
  } ctrl_t;

  // Moore decode: the control word depends only on state and op class.
  function automatic ctrl_t mc_ctrl(input mc_state_e s, input op_class_e c);
    ctrl_t w;
    w = '0;
    case (s)
      S_FETCH: begin
        w.pc_write = 1'b1;
        w.ir_write = 1'b1;
        w.mem_read = 1'b1;
        w.busy     = 1'b1;
      end
      S_DECODE: begin
        w.busy = 1'b1;
      end
      S_EXEC: begin
        w.busy = 1'b1;
        case (c)
          CLS_R: begin
            w.alu_op = ALUOP_FUNCT;
          end
          CLS_I: begin
            w.alu_op  = ALUOP_FUNCT;
            w.alu_src = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            w.alu_op  = ALUOP_ADD;
            w.alu_src = 1'b1;
          end
          CLS_BR: begin
            w.alu_op = ALUOP_SUB;
            w.branch = 1'b1;
          end
          default: begin
            w.alu_op = ALUOP_ADD;
          end
        endcase
      end
      S_MEM: begin
        w.busy      = 1'b1;
        w.alu_op    = ALUOP_ADD;
        w.alu_src   = 1'b1;
        w.mem_read  = (c == CLS_LD);
        w.mem_write = (c == CLS_ST);
      end
      S_WB: begin
        w.busy       = 1'b1;
        w.reg_write  = 1'b1;
        w.mem_to_reg = (c == CLS_LD);
      end
      default: begin
        w = '0;
      end
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: saturating memory wait counter with expiry compare against
// MEM_TIMEOUT (0 disables expiry). Requires 2**TO_W > MEM_TIMEOUT.
`default_nettype none

module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TO_W-1:0] c_limit   = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] c_max     = {TO_W{1'b1}};
  localparam logic            c_wdog_en = (MEM_TIMEOUT != 0);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expired = c_wdog_en && (r_cnt == c_limit);

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB over a
// variable-latency memory. Optional perf counters via MC_PERF_CNT_EN.
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
`ifdef MC_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             branch,
  output logic             reg_write,
  output logic             busy,
  output logic             illegal,
`ifdef MC_PERF_CNT_EN
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`else
  output logic             timeout
`endif
);

  mc_state_e r_state;
  mc_state_e w_state_nxt;
  op_class_e r_cls;
  op_class_e w_cls_nxt;
  ctrl_t     r_ctrl;
  logic      r_illegal;
  logic      r_timeout;
  logic      w_set_illegal;
  logic      w_set_timeout;
  logic      w_expired;
  logic      w_in_wait;
  logic      w_timer_clr;
  logic      w_timer_inc;

  always_comb begin
    w_state_nxt   = r_state;
    w_cls_nxt     = r_cls;
    w_set_illegal = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_state_nxt = S_DECODE;
        end else if (w_expired) begin
          w_state_nxt   = S_ERR;
          w_set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_EXEC;
        case (opcode)
          OP_R:  w_cls_nxt = CLS_R;
          OP_I:  w_cls_nxt = CLS_I;
          OP_LD: w_cls_nxt = CLS_LD;
          OP_ST: w_cls_nxt = CLS_ST;
          OP_BR: w_cls_nxt = CLS_BR;
          default: begin
            w_state_nxt   = S_ERR;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (r_cls)
          CLS_R, CLS_I:   w_state_nxt = S_WB;
          CLS_LD, CLS_ST: w_state_nxt = S_MEM;
          CLS_BR:         w_state_nxt = run ? S_FETCH : S_IDLE;
          default: begin
            w_state_nxt   = S_ERR;
            w_set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (r_cls == CLS_LD) w_state_nxt = S_WB;
          else                 w_state_nxt = run ? S_FETCH : S_IDLE;
        end else if (w_expired) begin
          w_state_nxt   = S_ERR;
          w_set_timeout = 1'b1;
        end
      end
      S_WB: begin
        w_state_nxt = run ? S_FETCH : S_IDLE;
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Every state change re-arms the watchdog, so each request starts from zero.
  assign w_in_wait   = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timer_clr = (w_state_nxt != r_state);
  assign w_timer_inc = w_in_wait && !mem_ready;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (w_timer_clr),
    .i_inc     (w_timer_inc),
    .o_expired (w_expired)
  );

  // Outputs are registered from the next state so they match the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cls     <= CLS_R;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cls     <= w_cls_nxt;
      r_ctrl    <= mc_ctrl(w_state_nxt, w_cls_nxt);
      r_illegal <= r_illegal | w_set_illegal;
      r_timeout <= r_timeout | w_set_timeout;
    end
  end

  assign pc_write   = r_ctrl.pc_write;
  assign ir_write   = r_ctrl.ir_write;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign alu_src    = r_ctrl.alu_src;
  assign alu_op     = r_ctrl.alu_op;
  assign branch     = r_ctrl.branch;
  assign reg_write  = r_ctrl.reg_write;
  assign busy       = r_ctrl.busy;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;

`ifdef MC_PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  assign w_retire = (r_state == S_WB)
                 || ((r_state == S_EXEC) && (r_cls == CLS_BR))
                 || ((r_state == S_MEM) && (r_cls == CLS_ST) && mem_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_ctrl.busy) r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (w_retire)    r_instret_cnt <= r_instret_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

`default_nettype wire
